// File: rtl/signal_delay_pkg.sv
// Shared types and helpers for the signal delay line: FSM state encoding and delay clamp.
package signal_delay_pkg;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Requested delays outside 1..max_d are pulled to the nearest legal value.
  function automatic int unsigned clamp_delay(input int unsigned req, input int unsigned max_d);
    int unsigned r;
    if (req == 32'd0) begin
      r = 32'd1;
    end else if (req > max_d) begin
      r = max_d;
    end else begin
      r = req;
    end
    return r;
  endfunction

endpackage

// File: rtl/signal_delay_ram.sv
// Ring buffer storage for the delay line: synchronous write, combinational read by index.
module signal_delay_ram #(
  parameter  int WIDTH = 1,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Storage write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/signal_delay_line.sv
// Programmable per-channel delay line with FILL/RUN masking.
// Define SIGNAL_DELAY_HALF_CYCLE_EN to add the optional falling-edge half-cycle output stage.
module signal_delay_line
  import signal_delay_pkg::*;
#(
  parameter  int WIDTH       = 1,
  parameter  int MAX_DELAY   = 16,
  parameter  int RESET_DELAY = 4,
  localparam int DW          = $clog2(MAX_DELAY + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] signal_in,
  input  logic [DW-1:0]    delay,
  input  logic             half_en,
  input  logic             delay_load,
  output logic [WIDTH-1:0] signal_out,
  output logic             ready
);

  localparam int AW = $clog2(MAX_DELAY);
  localparam int SW = DW + 1;

  state_e           state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [DW-1:0]    fill_cnt_q, fill_cnt_d;
  logic [DW-1:0]    d_q, d_d;
  logic             half_q, half_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             ready_q, ready_d;
  logic [SW-1:0]    rd_sum_s;
  logic [AW-1:0]    rd_idx_s;
  logic [WIDTH-1:0] rd_data_s;
  logic [WIDTH-1:0] raw_s;

  signal_delay_ram #(
    .WIDTH (WIDTH),
    .DEPTH (MAX_DELAY)
  ) u_ram (
    .clk     (clk),
    .we      (1'b1),
    .wr_addr (wr_ptr_q),
    .wr_data (signal_in),
    .rd_addr (rd_idx_s),
    .rd_data (rd_data_s)
  );

  // Read index and delayed sample; a delay of one forwards the word being written this edge.
  always_comb begin
    rd_sum_s = SW'(wr_ptr_q) + SW'(MAX_DELAY + 1) - SW'(d_q);
    if (rd_sum_s >= SW'(MAX_DELAY)) begin
      rd_idx_s = AW'(rd_sum_s - SW'(MAX_DELAY));
    end else begin
      rd_idx_s = AW'(rd_sum_s);
    end
    if (d_q == DW'(1)) begin
      raw_s = signal_in;
    end else begin
      raw_s = rd_data_s;
    end
  end

  // Next-state logic for pointer, committed setting, FILL/RUN control and masked outputs.
  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    d_d        = d_q;
    half_d     = half_q;
    if (wr_ptr_q == AW'(MAX_DELAY - 1)) begin
      wr_ptr_d = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (delay_load) begin
      d_d        = DW'(clamp_delay(32'(delay), 32'(MAX_DELAY)));
`ifdef SIGNAL_DELAY_HALF_CYCLE_EN
      half_d     = half_en;
`else
      half_d     = 1'b0;
`endif
      fill_cnt_d = '0;
      state_d    = FILL;
    end else begin
      case (state_q)
        FILL: begin
          if ((fill_cnt_q + DW'(1)) >= (d_q - DW'(1))) begin
            state_d = RUN;
          end else begin
            fill_cnt_d = fill_cnt_q + DW'(1);
          end
        end
        RUN:     state_d = RUN;
        default: state_d = FILL;
      endcase
    end
    if (state_d == RUN) begin
      out_d   = raw_s;
      ready_d = 1'b1;
    end else begin
      out_d   = '0;
      ready_d = 1'b0;
    end
  end

  // Rising-edge state: control FSM, pointer, committed setting and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FILL;
      wr_ptr_q   <= '0;
      fill_cnt_q <= '0;
      d_q        <= DW'(RESET_DELAY);
      half_q     <= 1'b0;
      out_q      <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      fill_cnt_q <= fill_cnt_d;
      d_q        <= d_d;
      half_q     <= half_d;
      out_q      <= out_d;
      ready_q    <= ready_d;
    end
  end

`ifdef SIGNAL_DELAY_HALF_CYCLE_EN
  logic [WIDTH-1:0] out_h_q;
  logic             ready_h_q;

  // Falling-edge retime so data and ready move together in half mode.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      out_h_q   <= '0;
      ready_h_q <= 1'b0;
    end else begin
      out_h_q   <= out_q;
      ready_h_q <= ready_q;
    end
  end

  assign signal_out = half_q ? out_h_q : out_q;
  assign ready      = half_q ? ready_h_q : ready_q;
`else
  logic half_en_unused_s;
  assign half_en_unused_s = half_en;
  assign signal_out       = out_q;
  assign ready            = ready_q;
`endif

endmodule

// File: doc/signal_delay_line.md
SIGNAL_DELAY_LINE -- requirements
Module: signal_delay_line

Interface
REQ-001 Parameter WIDTH, default 1: number of independent signal channels delayed in parallel.
REQ-002 Parameter MAX_DELAY, default 16: largest supported delay in whole clock cycles, at least 2.
REQ-003 Parameter RESET_DELAY, default 4: delay in effect after reset, from 1 to MAX_DELAY.
REQ-004 Localparam DW = clog2(MAX_DELAY+1): width of the delay field.
REQ-005 clk  in  1  single clock; all state is on its rising edge except the half-cycle stage.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 signal_in  in  WIDTH  channel inputs, sampled on rising clk.
REQ-008 delay  in  DW  requested delay D in cycles, captured only on delay_load.
REQ-009 half_en  in  1  requested extra half-cycle delay, captured only on delay_load.
REQ-010 delay_load  in  1  single-cycle strobe; commits delay and half_en.
REQ-011 signal_out  out  WIDTH  delayed channels.
REQ-012 ready  out  1  high when signal_out carries valid delayed data for the committed setting.

Function
REQ-013 Storage SHALL be a MAX_DELAY-entry ring buffer with write pointer wr_ptr, which increments every cycle and wraps from MAX_DELAY-1 to 0.
REQ-014 Committed delay D_q SHALL be clamped: delay=0 commits 1, delay>MAX_DELAY commits MAX_DELAY.
REQ-015 With half mode off, a sample captured at rising edge n SHALL appear on signal_out immediately after rising edge n+D_q-1 (D_q=1 equals one plain flop).
REQ-016 With half mode on, the same sample SHALL instead appear after the falling edge following rising edge n+D_q-1.
REQ-017 Read index SHALL be (wr_ptr - D_q + 1) modulo MAX_DELAY, with no out-of-range access at any D_q.
REQ-018 The control FSM SHALL have states FILL and RUN; reset enters FILL.
REQ-019 In FILL, fill_cnt SHALL count rising edges from 0; the FSM SHALL move to RUN on the edge where fill_cnt reaches D_q-1.
REQ-020 ready SHALL be 0 in FILL and 1 in RUN; in FILL, signal_out SHALL be forced to all zeros.
REQ-021 delay_load in either state SHALL commit the new D_q and half setting on that edge, clear fill_cnt and enter FILL. Reloading the same value SHALL also restart FILL.
REQ-022 delay_load SHALL NOT clear the ring buffer. Stale samples are hidden only by the FILL masking.
REQ-023 In half mode, ready SHALL be retimed through the same falling-edge stage as signal_out, so both change together.
REQ-024 Channels SHALL be fully independent, with no cross-channel logic.

Reset
REQ-025 While rst is high, the following SHALL hold asynchronously: signal_out=0, ready=0, wr_ptr=0, fill_cnt=0, state=FILL, D_q=RESET_DELAY, half mode off.
REQ-026 Ring buffer contents need not be reset. After reset deasserts, outputs SHALL follow REQ-019 and REQ-020.
REQ-027 Reset asserted mid-FILL or mid-RUN SHALL discard any pending delay_load.

Configuration
REQ-028 Macro SIGNAL_DELAY_HALF_CYCLE_EN SHALL compile in the falling-edge output stage and half mode.
REQ-029 Without SIGNAL_DELAY_HALF_CYCLE_EN, no negedge logic SHALL exist. half_en SHALL be ignored, and timing SHALL always follow REQ-015.

Structure
REQ-030 Package signal_delay_pkg SHALL hold the FILL/RUN state typedef and the delay-clamp function.
REQ-031 The ring buffer SHALL be a sub-module, signal_delay_ram: WIDTH x MAX_DELAY, synchronous write, combinational read by index.
REQ-032 signal_delay_line SHALL contain the FSM, pointers, clamp, masking and optional half-cycle stage.

Verification
REQ-033 Reset release with WIDTH=4: ready rises after 3 more edges (RESET_DELAY=4); input 0xA at edge n is seen as 0xA after edge n+3.
REQ-034 delay_load with delay=1: next sample is seen after the same edge; ready falls for 0 cycles of FILL beyond the load edge and is 1 after the next edge.
REQ-035 delay=0 and delay=MAX_DELAY+5: latency equals 1 and MAX_DELAY respectively, with no X on signal_out across the wr_ptr wrap.
REQ-036 With SIGNAL_DELAY_HALF_CYCLE_EN, half_en=1, delay=4: the pulse at edge n appears at the falling edge after edge n+3, and ready rises on a falling edge.
REQ-037 A delay_load during FILL (delay 8, then 3 after 2 cycles) gives ready 2 edges after the second load, and signal_out stays 0 meanwhile.
REQ-038 rst pulsed mid-RUN between clock edges: signal_out and ready drop to 0 immediately, and D_q returns to RESET_DELAY.
